// File: rtl/cycle_monitor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cycle_monitor_pkg
//  Description : Shared word width and run-state encoding for cycle_monitor.
//  Revision    : 1.0  initial release
// ============================================================================
package cycle_monitor_pkg;

    localparam int unsigned WORD = 16;

    typedef enum logic [1:0] {
        CM_IDLE = 2'd0,
        CM_RUN  = 2'd1,
        CM_DONE = 2'd2,
        CM_TOUT = 2'd3
    } cm_state_e;

endpackage : cycle_monitor_pkg
`default_nettype wire

// File: rtl/cycle_monitor_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that sticks at all-ones instead of wrapping.
//  Revision    : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && !(&q_q)) begin
            q_d = q_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/cycle_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : cycle_monitor
//  Description : Run/halt cycle counter with per-channel event counters and
//                a watchdog that ends a run after TIMEOUT counted cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module cycle_monitor
    import cycle_monitor_pkg::*;
#(
    parameter int unsigned WIDTH   = WORD,
    parameter int unsigned N_EVT   = 4,
    parameter int unsigned TIMEOUT = 45
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   halt,
    input  logic                   clr,
    input  logic [N_EVT-1:0]       evt,
    output logic [WIDTH-1:0]       cycles,
    output logic [N_EVT*WIDTH-1:0] evt_cnt,
    output logic                   running,
    output logic                   done,
    output logic                   timeout,
    output logic                   ovf
);

    // A limit that cannot be represented in WIDTH bits is never reached.
    localparam logic             TO_EN  = (TIMEOUT != 0) &&
                                          ((64'(TIMEOUT) >> WIDTH) == 64'd0);
    localparam logic [WIDTH-1:0] TO_VAL = WIDTH'(TIMEOUT);

    cm_state_e        state_q,   state_d;
    logic [WIDTH-1:0] cycles_q,  cycles_d;
    logic             running_q, running_d;
    logic             done_q,    done_d;
    logic             timeout_q, timeout_d;
    logic             ovf_q,     ovf_d;

    logic [WIDTH-1:0] cyc_inc;
    logic             cnt_clr;
    logic             cnt_run;

    assign cyc_inc = cycles_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cycles_d  = cycles_q;
        running_d = running_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        ovf_d     = ovf_q;
        cnt_clr   = 1'b0;
        cnt_run   = 1'b0;

        if (clr) begin
            state_d   = CM_IDLE;
            cycles_d  = '0;
            running_d = 1'b0;
            done_d    = 1'b0;
            timeout_d = 1'b0;
            ovf_d     = 1'b0;
            cnt_clr   = 1'b1;
        end else begin
            case (state_q)
                CM_RUN: begin
                    cycles_d = cyc_inc;
                    cnt_run  = 1'b1;
                    if (&cycles_q) begin
                        ovf_d = 1'b1;
                    end
                    // The halting cycle is still counted; halt beats the watchdog.
                    if (halt) begin
                        state_d   = CM_DONE;
                        running_d = 1'b0;
                        done_d    = 1'b1;
                    end else if (TO_EN && (cyc_inc == TO_VAL)) begin
                        state_d   = CM_TOUT;
                        running_d = 1'b0;
                        timeout_d = 1'b1;
                    end
                end
                default: begin
                    if (start) begin
                        state_d   = CM_RUN;
                        cycles_d  = '0;
                        running_d = 1'b1;
                        done_d    = 1'b0;
                        timeout_d = 1'b0;
                        ovf_d     = 1'b0;
                        cnt_clr   = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= CM_IDLE;
            cycles_q  <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cycles_q  <= cycles_d;
            running_q <= running_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            ovf_q     <= ovf_d;
        end
    end

    generate
        for (genvar i = 0; i < N_EVT; i++) begin : g_evt
            sat_counter #(
                .WIDTH (WIDTH)
            ) u_cnt (
                .clk (clk),
                .rst (rst),
                .clr (cnt_clr),
                .inc (cnt_run & evt[i]),
                .q   (evt_cnt[i*WIDTH +: WIDTH])
            );
        end
    endgenerate

    assign cycles  = cycles_q;
    assign running = running_q;
    assign done    = done_q;
    assign timeout = timeout_q;
    assign ovf     = ovf_q;

endmodule : cycle_monitor
`default_nettype wire

// File: tb/tb_cycle_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cycle_monitor
//  Description : Self-checking bench for cycle_monitor: a 16-bit/TIMEOUT=45
//                and a 4-bit/no-watchdog instance driven by shared stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cycle_monitor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        halt  = 1'b0;
    logic        clr   = 1'b0;
    logic [3:0]  evt   = 4'b0;

    logic [15:0] cyc16;
    logic [63:0] ev16;
    logic        run16, done16, to16, ovf16;
    logic [3:0]  cyc4;
    logic [15:0] ev4;
    logic        run4, done4, to4, ovf4;

    always #5 clk = ~clk;

    cycle_monitor #(.WIDTH(16), .N_EVT(4), .TIMEOUT(45)) dut (
        .clk(clk), .rst(rst), .start(start), .halt(halt), .clr(clr), .evt(evt),
        .cycles(cyc16), .evt_cnt(ev16), .running(run16), .done(done16),
        .timeout(to16), .ovf(ovf16)
    );

    cycle_monitor #(.WIDTH(4), .N_EVT(4), .TIMEOUT(0)) dut_w (
        .clk(clk), .rst(rst), .start(start), .halt(halt), .clr(clr), .evt(evt),
        .cycles(cyc4), .evt_cnt(ev4), .running(run4), .done(done4),
        .timeout(to4), .ovf(ovf4)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Reference model: index 0 = 16-bit/T45, index 1 = 4-bit/no watchdog.
    // m_st: 0 idle, 1 run, 2 done, 3 timed out.
    int     m_w[2]  = '{16, 4};
    int     m_to[2] = '{45, 0};
    int     m_st[2];
    longint m_cyc[2];
    longint m_evt[2][4];
    bit     m_done[2], m_tout[2], m_ovf[2];

    task automatic model_reset(input int k);
        m_st[k] = 0; m_cyc[k] = 0; m_done[k] = 0; m_tout[k] = 0; m_ovf[k] = 0;
        for (int i = 0; i < 4; i++) m_evt[k][i] = 0;
    endtask

    task automatic model_clock(input int k);
        longint top;
        top = (longint'(1) << m_w[k]) - 1;
        if (rst || clr) begin
            model_reset(k);
        end else if (m_st[k] == 1) begin
            for (int i = 0; i < 4; i++)
                if (evt[i] && m_evt[k][i] < top) m_evt[k][i]++;
            if (m_cyc[k] == top) m_ovf[k] = 1;
            m_cyc[k] = (m_cyc[k] + 1) % (top + 1);
            if (halt) begin
                m_st[k] = 2; m_done[k] = 1;
            end else if (m_to[k] != 0 && m_cyc[k] == m_to[k]) begin
                m_st[k] = 3; m_tout[k] = 1;
            end
        end else if (start) begin
            model_reset(k);
            m_st[k] = 1;
        end
    endtask

    task automatic compare_all(input string ph);
        check_val({ph, ".cyc16"}, longint'(cyc16), m_cyc[0]);
        check_val({ph, ".run16"}, longint'(run16), longint'(m_st[0] == 1));
        check_val({ph, ".done16"}, longint'(done16), longint'(m_done[0]));
        check_val({ph, ".tout16"}, longint'(to16), longint'(m_tout[0]));
        check_val({ph, ".ovf16"}, longint'(ovf16), longint'(m_ovf[0]));
        check_val({ph, ".cyc4"}, longint'(cyc4), m_cyc[1]);
        check_val({ph, ".run4"}, longint'(run4), longint'(m_st[1] == 1));
        check_val({ph, ".done4"}, longint'(done4), longint'(m_done[1]));
        check_val({ph, ".tout4"}, longint'(to4), longint'(m_tout[1]));
        check_val({ph, ".ovf4"}, longint'(ovf4), longint'(m_ovf[1]));
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("%s.evt16[%0d]", ph, i), longint'(ev16[i*16 +: 16]), m_evt[0][i]);
            check_val($sformatf("%s.evt4[%0d]", ph, i), longint'(ev4[i*4 +: 4]), m_evt[1][i]);
        end
    endtask

    task automatic step(input string ph);
        model_clock(0);
        model_clock(1);
        @(posedge clk);
        #1;
        compare_all(ph);
    endtask

    task automatic drive(input bit s, input bit h, input bit c, input logic [3:0] e);
        start = s; halt = h; clr = c; evt = e;
    endtask

    initial begin
        model_reset(0);
        model_reset(1);

        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        compare_all("reset");
        rst = 1'b0;
        drive(0, 0, 0, 4'hF);
        repeat (10) step("idle");

        // Halt stop after 20 counted cycles
        drive(1, 0, 0, 4'h0); step("h_start");
        check_val("h_start.cycles0", longint'(cyc16), 0);
        drive(0, 0, 0, 4'h0);
        repeat (19) step("h_run");
        drive(0, 1, 0, 4'h0); step("h_halt");
        check_val("halt.cycles20", longint'(cyc16), 20);
        check_val("halt.done", longint'(done16), 1);
        drive(0, 0, 0, 4'hF);
        repeat (10) step("h_frozen");
        check_val("halt.frozen20", longint'(cyc16), 20);

        // Watchdog fires at 45
        drive(1, 0, 0, 4'h0); step("w_start");
        drive(0, 0, 0, 4'h0);
        repeat (45) step("w_run");
        check_val("wd.timeout", longint'(to16), 1);
        check_val("wd.cycles45", longint'(cyc16), 45);
        repeat (5) step("w_frozen");
        check_val("wd.frozen45", longint'(cyc16), 45);

        // Halt coinciding with cycle 45 wins
        drive(1, 0, 0, 4'h0); step("wh_start");
        drive(0, 0, 0, 4'h0);
        repeat (44) step("wh_run");
        drive(0, 1, 0, 4'h0); step("wh_halt");
        check_val("wh.done", longint'(done16), 1);
        check_val("wh.timeout", longint'(to16), 0);

        // Events: pre-start events ignored, 4-bit counters saturate
        drive(0, 0, 1, 4'b0101); step("e_clr");
        drive(0, 0, 0, 4'b0101); repeat (3) step("e_pre");
        drive(1, 0, 0, 4'b0101); step("e_start");
        drive(0, 0, 0, 4'b0101); repeat (20) step("e_run");
        check_val("evt4.ch0_sat", longint'(ev4[3:0]), 15);
        check_val("evt4.ch1_zero", longint'(ev4[7:4]), 0);
        check_val("evt16.ch2", longint'(ev16[47:32]), 20);

        // Wrap on the 4-bit instance after 17 cycles
        drive(0, 0, 1, 4'h0); step("r_clr");
        drive(1, 0, 0, 4'h0); step("r_start");
        drive(0, 0, 0, 4'h0); repeat (17) step("r_run");
        check_val("wrap.cycles1", longint'(cyc4), 1);
        check_val("wrap.ovf", longint'(ovf4), 1);
        check_val("wrap.running", longint'(run4), 1);

        // clr and start together
        drive(0, 1, 0, 4'h0); step("p_halt");
        drive(1, 0, 1, 4'hF); step("p_clr_start");
        check_val("prio.running", longint'(run16), 0);

        // Async reset mid-run
        drive(1, 0, 0, 4'hF); step("a_start");
        drive(0, 0, 0, 4'hF); repeat (5) step("a_run");
        #3;
        rst = 1'b1;
        #1;
        model_reset(0);
        model_reset(1);
        compare_all("a_async");
        step("a_hold");
        rst = 1'b0;
        repeat (3) step("a_after");

        // Randomized traffic
        for (int n = 0; n < 1500; n++) begin
            drive($urandom_range(0, 19) == 0, $urandom_range(0, 29) == 0,
                  $urandom_range(0, 79) == 0, 4'($urandom));
            step("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_cycle_monitor
`default_nettype wire
